// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the shift sequencer.
package shift_seq_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefAmtW  = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational one-position left-shift stage; passes d through when en is low.
module shift_step #(
    parameter int unsigned WIDTH = shift_seq_pkg::DefWidth
) (
    input  logic             en,
    input  logic             fill,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = en ? {d[WIDTH-2:0], fill} : d;
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle left shifter iterating shift_step once per clock.
// Define SHIFT_SEQ_ROTATE_EN to rotate (fill with the MSB) instead of shifting in zeros.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned AMT_W = DefAmtW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] step_q;
    logic             step_en;
    logic             fill;

`ifdef SHIFT_SEQ_ROTATE_EN
    assign fill = data_q[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    assign step_en = (state_q == StShift);

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .en  (step_en),
        .fill(fill),
        .d   (data_q),
        .q   (step_q)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = in_amt;
                    state_d = (in_amt != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                data_d = step_q;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset wins over any handshake; an in-flight request is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q == StShift) || (state_q == StDone);
        out_data  = data_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (WIDTH=8, AMT_W=3).
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int checks;
    int failures;

    shift_sequencer #(
        .WIDTH(8),
        .AMT_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 3'd0;
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        cyc();

        // 0x01 << 3, out_valid three cycles after the accept edge
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_amt   = 3'd3;
        cyc();
        in_valid = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        chk("t1_ov_e0", 32'(out_valid), 32'd0);
        cyc();
        chk("t1_ov_e1", 32'(out_valid), 32'd0);
        cyc();
        chk("t1_ov_e2", 32'(out_valid), 32'd0);
        cyc();
        chk("t1_ov_e3", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h08);
        cyc();
        chk("t1_idle_ready", 32'(in_ready), 32'd1);
        chk("t1_idle_ov", 32'(out_valid), 32'd0);

        // 0x81 by 1: shift drops the MSB, rotate wraps it
        in_valid = 1'b1;
        in_data  = 8'h81;
        in_amt   = 3'd1;
        cyc();
        in_valid = 1'b0;
        chk("t2_ov_e0", 32'(out_valid), 32'd0);
        cyc();
        chk("t2_ov", 32'(out_valid), 32'd1);
`ifdef SHIFT_SEQ_ROTATE_EN
        chk("t2_data", 32'(out_data), 32'h03);
`else
        chk("t2_data", 32'(out_data), 32'h02);
`endif
        cyc();

        // amt=0 goes straight to DONE
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_amt   = 3'd0;
        cyc();
        in_valid = 1'b0;
        chk("t3_ov", 32'(out_valid), 32'd1);
        chk("t3_data", 32'(out_data), 32'hA5);
        cyc();
        chk("t3_idle", 32'(in_ready), 32'd1);

        // Backpressure: result held while out_ready=0, new requests ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0F;
        in_amt    = 3'd2;
        cyc();
        in_data = 8'hFF;
        in_amt  = 3'd5;
        cyc();
        chk("t4_ov_e1", 32'(out_valid), 32'd0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_ov", 32'(out_valid), 32'd1);
            chk("t4_hold_data", 32'(out_data), 32'h3C);
            chk("t4_hold_ready", 32'(in_ready), 32'd0);
            if (i < 4) cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("t4_idle_ready", 32'(in_ready), 32'd1);
        chk("t4_idle_ov", 32'(out_valid), 32'd0);
        chk("t4_idle_busy", 32'(busy), 32'd0);

        // Reset during the third SHIFT cycle discards the request
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_amt   = 3'd7;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_ov", 32'(out_valid), 32'd0);
        chk("t5_data", 32'(out_data), 32'h00);
        chk("t5_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t5_no_result", 32'(out_valid), 32'd0);
        end

        // Back-to-back requests with in_valid held
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_amt   = 3'd1;
        cyc();
        chk("t6_a_busy", 32'(busy), 32'd1);
        in_amt = 3'd2;
        cyc();
        chk("t6_a_ov", 32'(out_valid), 32'd1);
        chk("t6_a_data", 32'(out_data), 32'h02);
        cyc();
        chk("t6_gap_ready", 32'(in_ready), 32'd1);
        chk("t6_gap_ov", 32'(out_valid), 32'd0);
        cyc();
        in_valid = 1'b0;
        chk("t6_b_accept", 32'(busy), 32'd1);
        cyc();
        chk("t6_b_ov_e1", 32'(out_valid), 32'd0);
        cyc();
        chk("t6_b_ov", 32'(out_valid), 32'd1);
        chk("t6_b_data", 32'(out_data), 32'h04);
        cyc();
        chk("t6_end_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
